ps2_cursor_ctrl: RTL and testbench

- Sits between the PS/2 receiver (ps2_rx) and the VGA controller. Consumes received scan-code bytes.
- Tracks make/break state of the four direction keys (WASD plus the extended arrow keys).
- Once per video frame, steps a registered overlay-sprite position that is clamped to the visible area.
- Drives xCoord/yCoord of the overlay compositor, replacing the ad-hoc scan_out compare.

---
 rtl/ps2_keys_pkg.sv | 72 +++++++
 rtl/ps2_cursor_ctrl_if.sv | 25 ++
 rtl/ps2_key_decoder.sv | 59 +++++
 rtl/ps2_cursor_ctrl.sv | 75 +++++++
 tb/tb_ps2_cursor_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 scan-code constants, decoder state encoding and cursor step helper
// for the keyboard-driven overlay cursor.
package ps2_keys_pkg;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;
   localparam logic [7:0] SC_W   = 8'h1D;
   localparam logic [7:0] SC_S   = 8'h1B;
   localparam logic [7:0] SC_A   = 8'h1C;
   localparam logic [7:0] SC_D   = 8'h23;
   localparam logic [7:0] SC_ESC = 8'h76;
   localparam logic [7:0] SC_UP  = 8'h75;
   localparam logic [7:0] SC_DN  = 8'h72;
   localparam logic [7:0] SC_LT  = 8'h6B;
   localparam logic [7:0] SC_RT  = 8'h74;

   localparam int COORD_W = 10;

   // keys_held bit positions: {up, down, left, right}
   localparam int KEY_UP = 3;
   localparam int KEY_DN = 2;
   localparam int KEY_LT = 1;
   localparam int KEY_RT = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } dec_state_t;

   function automatic logic [3:0] key_mask(input logic [7:0] code, input logic ext);
      logic [3:0] m;
      m = 4'b0000;
      if (!ext) begin
         case (code)
            SC_W:    m[KEY_UP] = 1'b1;
            SC_S:    m[KEY_DN] = 1'b1;
            SC_A:    m[KEY_LT] = 1'b1;
            SC_D:    m[KEY_RT] = 1'b1;
            default: m = 4'b0000;
         endcase
      end else begin
         case (code)
            SC_UP:   m[KEY_UP] = 1'b1;
            SC_DN:   m[KEY_DN] = 1'b1;
            SC_LT:   m[KEY_LT] = 1'b1;
            SC_RT:   m[KEY_RT] = 1'b1;
            default: m = 4'b0000;
         endcase
      end
      return m;
   endfunction

   // One axis step; opposing keys cancel. The sum is 11 bits so the clamp never sees a wrap.
   function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c,
                                                     input logic dec,
                                                     input logic inc,
                                                     input logic [COORD_W-1:0] max_c,
                                                     input logic [3:0] step);
      logic [COORD_W:0]   sum;
      logic [COORD_W-1:0] step_ext;
      step_ext = {{(COORD_W-4){1'b0}}, step};
      sum      = {1'b0, c} + {1'b0, step_ext};
      if (dec && !inc)
         return (c < step_ext) ? '0 : c - step_ext;
      else if (inc && !dec)
         return (sum > {1'b0, max_c}) ? max_c : sum[COORD_W-1:0];
      return c;
   endfunction

endpackage

// File: rtl/ps2_cursor_ctrl_if.sv
// Bus between the PS/2 receiver / video timing side and the cursor controller.
interface ps2_cursor_ctrl_if;
   import ps2_keys_pkg::*;

   // rx_done_tick is a valid-only pulse: rx_data is valid on that cycle and the
   // controller always accepts it (no ready). frame_tick is a level; only its rising edge counts.
   logic               rx_done_tick;
   logic [7:0]         rx_data;
   logic               frame_tick;
   logic [COORD_W-1:0] x_coord;
   logic [COORD_W-1:0] y_coord;
   logic [3:0]         keys_held;
   logic               moving;
   dec_state_t         dec_state;

   modport master (
      output rx_done_tick, rx_data, frame_tick,
      input  x_coord, y_coord, keys_held, moving, dec_state
   );

   modport slave (
      input  rx_done_tick, rx_data, frame_tick,
      output x_coord, y_coord, keys_held, moving, dec_state
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// Scan-code packet FSM: tracks held direction keys and a sticky recenter request.
module ps2_key_decoder
   import ps2_keys_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   input  logic       recenter_clr,
   output logic [3:0] keys_held,
   output logic       recenter_req,
   output dec_state_t state
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         keys_held    <= 4'b0000;
         recenter_req <= 1'b0;
      end else begin
         if (recenter_clr)
            recenter_req <= 1'b0;
         // A new Esc make later in this block overrides the clear, so it survives to the next frame.
         if (rx_done_tick) begin
            case (state)
               ST_IDLE: begin
                  if (rx_data == SC_EXT)
                     state <= ST_EXT;
                  else if (rx_data == SC_BRK)
                     state <= ST_BRK;
                  else begin
                     keys_held <= keys_held | key_mask(rx_data, 1'b0);
                     if (rx_data == SC_ESC)
                        recenter_req <= 1'b1;
                  end
               end
               ST_BRK: begin
                  keys_held <= keys_held & ~key_mask(rx_data, 1'b0);
                  state     <= ST_IDLE;
               end
               ST_EXT: begin
                  if (rx_data == SC_BRK)
                     state <= ST_EXT_BRK;
                  else begin
                     keys_held <= keys_held | key_mask(rx_data, 1'b1);
                     state     <= ST_IDLE;
                  end
               end
               ST_EXT_BRK: begin
                  keys_held <= keys_held & ~key_mask(rx_data, 1'b1);
                  state     <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_cursor_ctrl.sv
// Keyboard-driven overlay cursor: decodes direction keys and steps a clamped
// sprite position once per video frame.
module ps2_cursor_ctrl
   import ps2_keys_pkg::*;
#(
   parameter int X_MAX  = 589,
   parameter int Y_MAX  = 429,
   parameter int X_INIT = 0,
   parameter int Y_INIT = 0,
   parameter int STEP   = 4
) (
   input logic               clk,
   input logic               reset,
   ps2_cursor_ctrl_if.slave  bus
);

   localparam logic [COORD_W-1:0] X_MAX_C  = X_MAX[COORD_W-1:0];
   localparam logic [COORD_W-1:0] Y_MAX_C  = Y_MAX[COORD_W-1:0];
   localparam logic [COORD_W-1:0] X_INIT_C = X_INIT[COORD_W-1:0];
   localparam logic [COORD_W-1:0] Y_INIT_C = Y_INIT[COORD_W-1:0];
   localparam logic [3:0]         STEP_C   = STEP[3:0];

   logic               frame_q;
   logic               frame_edge;
   logic               recenter_req;
   logic [3:0]         keys;
   logic [COORD_W-1:0] x_q, y_q;
   logic [COORD_W-1:0] next_x, next_y;
   logic               moving_q;

   ps2_key_decoder u_dec (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (bus.rx_done_tick),
      .rx_data      (bus.rx_data),
      .recenter_clr (frame_edge),
      .keys_held    (keys),
      .recenter_req (recenter_req),
      .state        (bus.dec_state)
   );

   assign frame_edge = bus.frame_tick & ~frame_q;

   // Uses flags as registered before this edge; a byte landing now only affects the next frame.
   assign next_x = step_coord(x_q, keys[KEY_LT], keys[KEY_RT], X_MAX_C, STEP_C);
   assign next_y = step_coord(y_q, keys[KEY_UP], keys[KEY_DN], Y_MAX_C, STEP_C);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_q  <= 1'b0;
         x_q      <= X_INIT_C;
         y_q      <= Y_INIT_C;
         moving_q <= 1'b0;
      end else begin
         frame_q <= bus.frame_tick;
         if (frame_edge) begin
            if (recenter_req) begin
               x_q      <= X_INIT_C;
               y_q      <= Y_INIT_C;
               moving_q <= (x_q != X_INIT_C) || (y_q != Y_INIT_C);
            end else begin
               x_q      <= next_x;
               y_q      <= next_y;
               moving_q <= (next_x != x_q) || (next_y != y_q);
            end
         end
      end
   end

   assign bus.x_coord   = x_q;
   assign bus.y_coord   = y_q;
   assign bus.keys_held = keys;
   assign bus.moving    = moving_q;

endmodule

// File: tb/tb_ps2_cursor_ctrl.sv
// Randomized scoreboard bench for ps2_cursor_ctrl with a packet-level key model.
module tb_ps2_cursor_ctrl;
   import ps2_keys_pkg::*;

   localparam int X_MAX  = 589;
   localparam int Y_MAX  = 429;
   localparam int X_INIT = 0;
   localparam int Y_INIT = 0;
   localparam int STEP   = 4;

   logic clk;
   logic reset;
   ps2_cursor_ctrl_if bus ();

   ps2_cursor_ctrl #(
      .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT), .STEP(STEP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int         mx, my;
   bit         h_up, h_dn, h_lt, h_rt;
   bit         req;
   bit         mv;
   logic [7:0] pkt[$];
   logic [24:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic logic [3:0] model_keys();
      return {h_up, h_dn, h_lt, h_rt};
   endfunction

   function void model_reset();
      mx = X_INIT; my = Y_INIT;
      h_up = 0; h_dn = 0; h_lt = 0; h_rt = 0;
      req = 0; mv = 0;
      pkt.delete();
   endfunction

   // Bytes accumulate into a packet; E0 may only lead, F0 may follow nothing or a lone E0.
   function void model_byte(input logic [7:0] b);
      bit ext, brk, val;
      if (pkt.size() == 0 && b == 8'hE0)
         pkt.push_back(b);
      else if (b == 8'hF0 && (pkt.size() == 0 || (pkt.size() == 1 && pkt[0] == 8'hE0)))
         pkt.push_back(b);
      else begin
         ext = (pkt.size() > 0 && pkt[0] == 8'hE0);
         brk = (pkt.size() > 0 && pkt[pkt.size()-1] == 8'hF0);
         val = !brk;
         if (!ext) begin
            if (b == 8'h1D) h_up = val;
            if (b == 8'h1B) h_dn = val;
            if (b == 8'h1C) h_lt = val;
            if (b == 8'h23) h_rt = val;
            if (b == 8'h76 && !brk) req = 1;
         end else begin
            if (b == 8'h75) h_up = val;
            if (b == 8'h72) h_dn = val;
            if (b == 8'h6B) h_lt = val;
            if (b == 8'h74) h_rt = val;
         end
         pkt.delete();
      end
   endfunction

   function automatic int axis(input int c, input int dir, input int max_c);
      int n;
      n = c + dir * STEP;
      if (n < 0) n = 0;
      if (n > max_c) n = max_c;
      return n;
   endfunction

   function void model_frame();
      int nx, ny;
      if (req) begin
         nx = X_INIT; ny = Y_INIT; req = 0;
      end else begin
         nx = axis(mx, int'(h_rt) - int'(h_lt), X_MAX);
         ny = axis(my, int'(h_dn) - int'(h_up), Y_MAX);
      end
      mv = (nx != mx) || (ny != my);
      mx = nx; my = ny;
   endfunction

   // driver tasks
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_done_tick = 1'b1;
      bus.rx_data      = b;
      model_byte(b);
      @(negedge clk);
      bus.rx_done_tick = 1'b0;
   endtask

   task automatic do_frame(input int len, input bit with_byte, input logic [7:0] b);
      @(negedge clk);
      bus.frame_tick = 1'b1;
      model_frame();
      if (with_byte) begin
         bus.rx_done_tick = 1'b1;
         bus.rx_data      = b;
         model_byte(b);
      end
      exp_q.push_back({10'(mx), 10'(my), model_keys(), mv});
      @(negedge clk);
      bus.rx_done_tick = 1'b0;
      repeat (len - 1) @(negedge clk);
      bus.frame_tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) do_frame(1, 1'b0, 8'h00);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_x"}, 32'(bus.x_coord), 32'(mx));
      check({tag, "_y"}, 32'(bus.y_coord), 32'(my));
      check({tag, "_keys"}, 32'(bus.keys_held), 32'(model_keys()));
      check({tag, "_moving"}, 32'(bus.moving), 32'(mv));
   endtask

   // monitor: one comparison per rising edge of frame_tick, one cycle later
   initial begin : monitor
      logic        ft_prev;
      logic [24:0] e;
      ft_prev = 1'b0;
      forever begin
         @(posedge clk);
         if (!reset) begin
            ft_prev = 1'b0;
         end else begin
            if (bus.frame_tick && !ft_prev) begin
               ft_prev = 1'b1;
               @(negedge clk);
               if (exp_q.size() == 0) begin
                  check("frame_without_expectation", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_x", 32'(bus.x_coord), 32'(e[24:15]));
                  check("frame_y", 32'(bus.y_coord), 32'(e[14:5]));
                  check("frame_keys", 32'(bus.keys_held), 32'(e[4:1]));
                  check("frame_moving", 32'(bus.moving), 32'(e[0]));
               end
            end else begin
               ft_prev = bus.frame_tick;
            end
         end
      end
   end

   logic [7:0] codes[14];

   initial begin : stimulus
      int pick;
      codes = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h76,
                8'h75, 8'h72, 8'h6B, 8'h74, 8'hAA, 8'hFA, 8'h00};
      bus.rx_done_tick = 1'b0;
      bus.rx_data      = 8'h00;
      bus.frame_tick   = 1'b0;
      reset = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset");
      check("reset_state", 32'(bus.dec_state), 32'(ST_IDLE));

      // right held: four frames of +4
      send_byte(8'h23);
      check("make_right_keys", 32'(bus.keys_held), 32'h1);
      frames(4);
      send_byte(8'hF0); send_byte(8'h23);
      check("break_right_keys", 32'(bus.keys_held), 32'h0);
      frames(1);

      // drive to the right edge, then back past zero
      send_byte(8'h23);
      frames(150);
      send_byte(8'hF0); send_byte(8'h23);
      send_byte(8'h1C);
      frames(152);
      send_byte(8'hF0); send_byte(8'h1C);

      // extended down to the bottom clamp, release, then opposing keys
      send_byte(8'hE0); send_byte(8'h72);
      frames(110);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
      check("ext_break_keys", 32'(bus.keys_held), 32'h0);
      send_byte(8'h1D); send_byte(8'h1B);
      check("opposed_keys", 32'(bus.keys_held), 32'hC);
      frames(2);
      send_byte(8'hF0); send_byte(8'h1B);
      frames(3);
      send_byte(8'hF0); send_byte(8'h1D);

      // recenter, then held keys resume; Esc break ignored
      send_byte(8'h23);
      frames(5);
      send_byte(8'h76);
      frames(2);
      send_byte(8'hF0); send_byte(8'h76);
      frames(1);

      // long frame_tick, and bytes landing on the frame-edge cycle
      do_frame(4, 1'b0, 8'h00);
      do_frame(2, 1'b1, 8'h1C);
      do_frame(1, 1'b1, 8'h76);
      frames(2);
      send_byte(8'hF0); send_byte(8'h1C);
      send_byte(8'hF0); send_byte(8'h23);

      // mid-packet frame, then reset between E0 and the key byte
      send_byte(8'h23);
      send_byte(8'hF0);
      frames(1);
      send_byte(8'h23);
      send_byte(8'hE0);
      #2 reset = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_idle_outputs("midpkt_reset");
      check("midpkt_reset_state", 32'(bus.dec_state), 32'(ST_IDLE));
      reset = 1'b1;
      send_byte(8'h74);
      check("post_reset_74_keys", 32'(bus.keys_held), 32'h0);
      frames(1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         pick = $urandom_range(0, 9);
         if (pick < 6)
            send_byte((pick == 5) ? 8'($urandom_range(0, 255)) : codes[$urandom_range(0, 13)]);
         else
            do_frame($urandom_range(1, 5), ($urandom_range(0, 3) == 0),
                     codes[$urandom_range(0, 13)]);
      end

      for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
